// File: rtl/hdd_sector_host.sv
// Host-side sector transfer engine for the ProDOS hard-disk slot.
// Watches the hdd block's read/write request levels, asks the storage image
// for the block, and moves 512 bytes between the image byte streams and the
// hdd sector buffer. Also mirrors mount / write-protect status back to hdd.
module hdd_sector_host #(
    parameter logic [31:0] BASE_LBA = 32'd0,
    parameter int unsigned TIMEOUT  = 1048576
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] hdd_sector,
    input  logic        hdd_read,
    input  logic        hdd_write,
    output logic        hdd_mounted,
    output logic        hdd_protect,
    output logic [8:0]  ram_addr,
    output logic [7:0]  ram_di,
    input  logic [7:0]  ram_do,
    output logic        ram_we,
    input  logic        img_mounted,
    input  logic        img_readonly,
    output logic [31:0] blk_lba,
    output logic        blk_rd,
    output logic        blk_wr,
    input  logic        blk_ack,
    input  logic [7:0]  rd_data,
    input  logic        rd_valid,
    output logic [7:0]  wr_data,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RREQ,
        S_RSTREAM,
        S_WREQ,
        S_WFETCH,
        S_WSEND,
        S_DONE
    } state_t;

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        rd_q, rd_qq, wr_q, wr_qq;
    logic [9:0]  cnt_q, cnt_d;
    logic [31:0] lba_q, lba_d;
    logic        err_q, err_d;
    logic [31:0] tmo_q, tmo_d;
    logic [8:0]  ram_addr_q, ram_addr_d;
    logic [7:0]  ram_di_q, ram_di_d;
    logic        ram_we_q, ram_we_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        mounted_q, protect_q;

    logic rd_rise, wr_rise, activity, waiting;

    // Edges are taken between two register stages so a request costs one
    // cycle to detect and one more to reach the state register.
    assign rd_rise = rd_q & ~rd_qq;
    assign wr_rise = wr_q & ~wr_qq;
    assign waiting = (state_q == S_RREQ) || (state_q == S_WREQ) ||
                     (state_q == S_RSTREAM) || (state_q == S_WSEND);

    // Next-state, datapath and watchdog decisions for one cycle.
    always_comb begin
        // NOTE: every signal gets its default first so no path can leave one unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        lba_d      = lba_q;
        err_d      = err_q;
        tmo_d      = '0;
        ram_addr_d = ram_addr_q;
        ram_di_d   = ram_di_q;
        ram_we_d   = 1'b0;
        wr_data_d  = wr_data_q;
        activity   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rd_rise || wr_rise) begin
                    lba_d      = BASE_LBA + {16'b0, hdd_sector};
                    cnt_d      = '0;
                    ram_addr_d = '0;   // first write-direction fetch address
                    err_d      = 1'b0;
                    if (!img_mounted || (!rd_rise && img_readonly)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (rd_rise) begin
                        state_d = S_RREQ;   // read wins a simultaneous edge
                    end else begin
                        state_d = S_WREQ;
                    end
                end
            end
            S_RREQ: begin
                if (blk_ack) state_d = S_RSTREAM;
            end
            S_RSTREAM: begin
                if (rd_valid) begin
                    activity   = 1'b1;
                    ram_addr_d = cnt_q[8:0];
                    ram_di_d   = rd_data;
                    ram_we_d   = 1'b1;
                    cnt_d      = cnt_q + 10'd1;
                    if (cnt_q == 10'd511) state_d = S_DONE;
                end
            end
            S_WREQ: begin
                if (blk_ack) state_d = S_WFETCH;
            end
            S_WFETCH: begin
                // The buffer sampled ram_addr at the edge that entered this
                // state, so ram_do already holds byte cnt. Point the address
                // at the next byte so it is read on the handshake edge.
                wr_data_d  = ram_do;
                ram_addr_d = cnt_q[8:0] + 9'd1;
                state_d    = S_WSEND;
            end
            S_WSEND: begin
                if (wr_ready) begin
                    activity = 1'b1;
                    cnt_d    = cnt_q + 10'd1;
                    state_d  = (cnt_q == 10'd511) ? S_DONE : S_WFETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Watchdog: counts only while stalled in a waiting state.
        if (waiting && !activity && (state_d == state_q)) begin
            if (tmo_q == TMO_LAST) begin
                state_d = S_DONE;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end
    end

    // State, datapath and status registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rd_q       <= 1'b0;
            rd_qq      <= 1'b0;
            wr_q       <= 1'b0;
            wr_qq      <= 1'b0;
            cnt_q      <= '0;
            lba_q      <= '0;
            err_q      <= 1'b0;
            tmo_q      <= '0;
            ram_addr_q <= '0;
            ram_di_q   <= '0;
            ram_we_q   <= 1'b0;
            wr_data_q  <= '0;
            mounted_q  <= 1'b0;
            protect_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q    <= state_d;
            rd_q       <= hdd_read;
            rd_qq      <= rd_q;
            wr_q       <= hdd_write;
            wr_qq      <= wr_q;
            cnt_q      <= cnt_d;
            lba_q      <= lba_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            ram_addr_q <= ram_addr_d;
            ram_di_q   <= ram_di_d;
            ram_we_q   <= ram_we_d;
            wr_data_q  <= wr_data_d;
            mounted_q  <= img_mounted;
            protect_q  <= img_readonly;
        end
    end

    assign hdd_mounted = mounted_q;
    assign hdd_protect = protect_q;
    assign ram_addr    = ram_addr_q;
    assign ram_di      = ram_di_q;
    assign ram_we      = ram_we_q;
    assign blk_lba     = lba_q;
    assign blk_rd      = (state_q == S_RREQ);
    assign blk_wr      = (state_q == S_WREQ);
    assign wr_data     = wr_data_q;
    assign wr_valid    = (state_q == S_WSEND);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign err         = err_q;

endmodule

// File: tb/tb_hdd_sector_host.sv
// Directed bench for hdd_sector_host: read, write with backpressure,
// rejected requests, dropped edges, watchdog abort and reset mid-stream.
module tb_hdd_sector_host;

    localparam int TMO = 16;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [15:0] hdd_sector;
    logic        hdd_read, hdd_write;
    logic        hdd_mounted, hdd_protect;
    logic [8:0]  ram_addr;
    logic [7:0]  ram_di, ram_do;
    logic        ram_we;
    logic        img_mounted, img_readonly;
    logic [31:0] blk_lba;
    logic        blk_rd, blk_wr, blk_ack;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [7:0]  wr_data;
    logic        wr_valid, wr_ready;
    logic        busy, done, err;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor counters (written only by the monitor process).
    int   we_cnt = 0, done_cnt = 0, rd_cyc = 0, wr_cyc = 0;
    int   hs_cnt = 0, wr_bad = 0, wr_unstable = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    // Sector buffer model: synchronous read, write strobe, bulk fill.
    logic       tb_fill = 1'b0;
    logic [7:0] mem [0:511];

    always #5 clk_sys = ~clk_sys;

    hdd_sector_host #(.BASE_LBA(32'd0), .TIMEOUT(TMO)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .hdd_sector   (hdd_sector),
        .hdd_read     (hdd_read),
        .hdd_write    (hdd_write),
        .hdd_mounted  (hdd_mounted),
        .hdd_protect  (hdd_protect),
        .ram_addr     (ram_addr),
        .ram_di       (ram_di),
        .ram_do       (ram_do),
        .ram_we       (ram_we),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .blk_lba      (blk_lba),
        .blk_rd       (blk_rd),
        .blk_wr       (blk_wr),
        .blk_ack      (blk_ack),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always @(posedge clk_sys) begin
        if (tb_fill) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'hA5 ^ 8'(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_di;
        end
        ram_do <= mem[ram_addr];
    end

    // Sample outputs mid-cycle; write data expected is 0xA5 ^ byte index.
    always @(negedge clk_sys) begin
        if (ram_we) we_cnt <= we_cnt + 1;
        if (done)   done_cnt <= done_cnt + 1;
        if (blk_rd) rd_cyc <= rd_cyc + 1;
        if (blk_wr) wr_cyc <= wr_cyc + 1;
        if (prev_stall && (!wr_valid || wr_data !== prev_data)) wr_unstable <= wr_unstable + 1;
        if (wr_valid && wr_ready) begin
            if (wr_data !== (8'hA5 ^ 8'(hs_cnt))) wr_bad <= wr_bad + 1;
            hs_cnt <= hs_cnt + 1;
        end
        prev_stall <= wr_valid && !wr_ready;
        prev_data  <= wr_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int sel, input int i);
        case (sel)
            0:       return 8'(i);
            1:       return 8'(i * 3 + 1);
            default: return 8'(~i);
        endcase
    endfunction

    function automatic logic [31:0] ctl_bits();
        return 32'({busy, done, err, blk_rd, blk_wr, ram_we, wr_valid, hdd_mounted, hdd_protect});
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Pulse a request, wait for the host strobe, acknowledge it.
    task automatic start_req(input bit is_wr, input bit both, input logic [15:0] sec, output int lat);
        bit seen = 1'b0;
        hdd_sector = sec;
        hdd_read   = !is_wr || both;
        hdd_write  = is_wr || both;
        tick();
        hdd_read  = 1'b0;
        hdd_write = 1'b0;
        lat = 99;
        for (int k = 0; k < 8; k++) begin
            if (is_wr ? blk_wr : blk_rd) begin
                lat  = k + 1;
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (seen) begin
            blk_ack = 1'b1;
            tick();
            blk_ack = 1'b0;
        end
    endtask

    task automatic stream(input int sel, input int first, input int n, input int poke_at);
        for (int i = first; i < first + n; i++) begin
            if (i % 64 == 32) begin
                rd_valid = 1'b0;
                tick();
            end
            hdd_read = (i == poke_at);
            rd_data  = pat(sel, i);
            rd_valid = 1'b1;
            tick();
        end
        rd_valid = 1'b0;
        hdd_read = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (cyc < budget) begin
            if (done) break;
            tick();
            cyc++;
        end
    endtask

    // mode 0: wr_ready high one cycle in three; mode 1: always ready.
    task automatic write_run(input int mode, output int cyc);
        cyc = 0;
        while (cyc < 2000) begin
            wr_ready = (mode == 1) || (cyc % 3 == 2);
            if (done) break;
            tick();
            cyc++;
        end
        wr_ready = 1'b0;
    endtask

    task automatic check_buf(input string tag, input int sel);
        int bad = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== pat(sel, i)) bad++;
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int lat, cyc, b_we, b_done, b_rd, b_wr, b_hs, b_bad;
        reset = 1'b1; hdd_sector = '0; hdd_read = 0; hdd_write = 0;
        img_mounted = 0; img_readonly = 0; blk_ack = 0;
        rd_data = '0; rd_valid = 0; wr_ready = 0;
        tick(); tick(); tick();
        reset = 1'b0;

        // Reset state and status lag.
        check("rst_ctrl", ctl_bits(), 32'd0);
        check("rst_lba", blk_lba, 32'd0);
        check("rst_ram", 32'({ram_addr, ram_di}), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        img_mounted = 1'b1;
        check("mounted_before", 32'(hdd_mounted), 32'd0);
        tick();
        check("mounted_lag", 32'(hdd_mounted), 32'd1);

        // Read sector 0x12 with pattern i & 0xFF.
        b_we = we_cnt; b_done = done_cnt;
        start_req(1'b0, 1'b0, 16'h0012, lat);
        check("rd_req_lat", 32'(lat), 32'd2);
        check("rd_ack_drop", 32'(blk_rd), 32'd0);
        check("rd_lba", blk_lba, 32'h0000_0012);
        check("rd_busy", 32'(busy), 32'd1);
        rd_data = pat(0, 0); rd_valid = 1'b1; tick();
        check("rd_first_we", 32'({ram_we, ram_addr}), 32'({1'b1, 9'd0}));
        rd_data = pat(0, 1); tick();
        check("rd_second_byte", 32'({ram_we, ram_addr, ram_di}), 32'({1'b1, 9'd1, 8'h01}));
        stream(0, 2, 510, -1);
        wait_done(8, cyc);
        check("rd_done_lat", 32'(cyc), 32'd0);
        check("rd_err", 32'(err), 32'd0);
        tick(); tick();
        check("rd_we_count", 32'(we_cnt - b_we), 32'd512);
        check("rd_done_count", 32'(done_cnt - b_done), 32'd1);
        check("rd_idle", 32'(busy), 32'd0);
        check_buf("rd_buffer", 0);

        // Write with backpressure, buffer holds 0xA5 ^ i.
        tb_fill = 1'b1; tick(); tb_fill = 1'b0; tick();
        b_hs = hs_cnt; b_done = done_cnt; b_bad = wr_bad;
        start_req(1'b1, 1'b0, 16'h0345, lat);
        check("wr_req_lat", 32'(lat), 32'd2);
        check("wr_lba", blk_lba, 32'h0000_0345);
        write_run(0, cyc);
        check("wr_bp_done", 32'(done), 32'd1);
        check("wr_bp_err", 32'(err), 32'd0);
        tick(); tick();
        check("wr_bp_bytes", 32'(hs_cnt - b_hs), 32'd512);
        check("wr_bp_data", 32'(wr_bad - b_bad), 32'd0);
        check("wr_bp_stable", 32'(wr_unstable), 32'd0);
        check("wr_bp_done_count", 32'(done_cnt - b_done), 32'd1);

        // Write at full rate: 2 cycles per byte.
        b_hs = hs_cnt;
        start_req(1'b1, 1'b0, 16'h0001, lat);
        write_run(1, cyc);
        check("wr_full_cycles", 32'(cyc), 32'd1024);
        tick(); tick();
        check("wr_full_bytes", 32'(hs_cnt - b_hs), 32'd512);
        check("wr_full_data", 32'(wr_bad - b_bad), 32'd0);

        // Write to a read-only image.
        img_readonly = 1'b1; tick();
        check("protect_lag", 32'(hdd_protect), 32'd1);
        b_wr = wr_cyc; b_done = done_cnt;
        hdd_write = 1'b1; tick(); hdd_write = 1'b0;
        wait_done(8, cyc);
        check("ro_done", 32'(done), 32'd1);
        check("ro_err", 32'(err), 32'd1);
        tick(); tick();
        check("ro_err_hold", 32'({err, busy}), 32'({1'b1, 1'b0}));
        check("ro_no_blk_wr", 32'(wr_cyc - b_wr), 32'd0);
        check("ro_done_count", 32'(done_cnt - b_done), 32'd1);

        // Read from an unmounted image.
        img_readonly = 1'b0; img_mounted = 1'b0; tick();
        b_rd = rd_cyc;
        hdd_read = 1'b1; tick(); hdd_read = 1'b0;
        wait_done(8, cyc);
        check("unm_done", 32'(done), 32'd1);
        check("unm_err", 32'(err), 32'd1);
        tick(); tick();
        check("unm_no_blk_rd", 32'(rd_cyc - b_rd), 32'd0);
        img_mounted = 1'b1; tick();

        // Simultaneous edges plus a dropped read edge mid-stream.
        b_we = we_cnt; b_done = done_cnt; b_wr = wr_cyc;
        start_req(1'b0, 1'b1, 16'h0100, lat);
        check("sim_req_lat", 32'(lat), 32'd2);
        check("sim_err_cleared", 32'(err), 32'd0);
        stream(2, 0, 512, 100);
        wait_done(8, cyc);
        check("sim_done_err", 32'({done, err}), 32'({1'b1, 1'b0}));
        tick(); tick(); tick(); tick();
        check("sim_we_count", 32'(we_cnt - b_we), 32'd512);
        check("sim_done_count", 32'(done_cnt - b_done), 32'd1);
        check("sim_no_write", 32'(wr_cyc - b_wr), 32'd0);
        check("sim_idle", 32'({busy, blk_rd}), 32'd0);
        check_buf("sim_buffer", 2);

        // Watchdog after 100 bytes.
        b_we = we_cnt;
        start_req(1'b0, 1'b0, 16'h0007, lat);
        stream(0, 0, 100, -1);
        wait_done(40, cyc);
        check("tmo_cycles", 32'(cyc), 32'd16);
        check("tmo_err", 32'(err), 32'd1);
        tick();
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_we_count", 32'(we_cnt - b_we), 32'd100);

        // Reset at byte 300, then a clean read.
        b_done = done_cnt;
        start_req(1'b0, 1'b0, 16'h0020, lat);
        stream(0, 0, 300, -1);
        reset = 1'b1; tick();
        check("rstm_ctrl", ctl_bits(), 32'd0);
        check("rstm_lba", blk_lba, 32'd0);
        check("rstm_ram", 32'({ram_addr, ram_di}), 32'd0);
        reset = 1'b0; tick(); tick();
        check("rstm_no_done", 32'(done_cnt - b_done), 32'd0);
        b_we = we_cnt; b_done = done_cnt;
        start_req(1'b0, 1'b0, 16'h0033, lat);
        check("rstm_req_lat", 32'(lat), 32'd2);
        check("rstm_lba_new", blk_lba, 32'h0000_0033);
        stream(1, 0, 512, -1);
        wait_done(8, cyc);
        check("rstm_done_err", 32'({done, err}), 32'({1'b1, 1'b0}));
        tick(); tick();
        check("rstm_we_count", 32'(we_cnt - b_we), 32'd512);
        check("rstm_done_count", 32'(done_cnt - b_done), 32'd1);
        check_buf("rstm_buffer", 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hdd_sector_host.md
# hdd_sector_host

Host-side sector transfer engine for the ProDOS hard-disk slot (slot 7). It sits in `top` opposite the `hdd` block. It watches the `hdd` block's `sector`, `hdd_read` and `hdd_write` outputs, requests the sector from the storage image interface, and moves 512 bytes between storage and the `hdd` sector buffer through that buffer's `ram_addr`/`ram_di`/`ram_do`/`ram_we` port. It also reports mount and write-protect status back to the `hdd` block.

## Interface
Parameters:
- `BASE_LBA`, default 0: offset added to the 16-bit sector number to form `blk_lba`.
- `TIMEOUT`, default 1048576: idle cycles allowed in any waiting state before the transfer aborts.

Ports:
- `clk_sys`  in  1  system clock; the only clock in the block.
- `reset`  in  1  synchronous reset, active-high.
- `hdd_sector`  in  16  sector number from `hdd`.
- `hdd_read`  in  1  read request level from `hdd`; a transfer starts on its rising edge.
- `hdd_write`  in  1  write request level from `hdd`; a transfer starts on its rising edge.
- `hdd_mounted`  out  1  registered copy of `img_mounted`.
- `hdd_protect`  out  1  registered copy of `img_readonly`.
- `ram_addr`  out  9  sector buffer byte address.
- `ram_di`  out  8  byte written into the sector buffer.
- `ram_do`  in  8  sector buffer read data; valid 1 cycle after `ram_addr`.
- `ram_we`  out  1  sector buffer write strobe.
- `img_mounted`, `img_readonly`  in  1 each  image status from the host.
- `blk_lba`  out  32  block address of the current request.
- `blk_rd`, `blk_wr`  out  1 each  request levels to the host.
- `blk_ack`  in  1  single-cycle pulse: host accepted the request.
- `rd_data`  in  8  read-direction byte stream.
- `rd_valid`  in  1  `rd_data` is valid this cycle.
- `wr_data`  out  8  write-direction byte stream.
- `wr_valid`  out  1  `wr_data` is valid.
- `wr_ready`  in  1  host accepts the byte when `wr_valid && wr_ready`.
- `busy`  out  1  transfer in progress.
- `done`  out  1  1-cycle pulse at the end of every transfer.
- `err`  out  1  status of the last transfer; valid when `done` pulses and held until the next transfer starts.

## Operation
- **Request detection.** `hdd_read` and `hdd_write` are registered, and a rising edge is detected on each.
  - A rising edge is acted on only in IDLE; edges seen in any other state are dropped.
  - If both rise in the same cycle, read wins and the write is dropped.
- **Request capture.** On acceptance, `blk_lba` is latched as `BASE_LBA + {16'b0, hdd_sector}` (32-bit addition, wraps), and the byte counter `cnt[9:0]` is cleared.
- **States:**
  - **IDLE.** All strobes low.
    - Read edge → RREQ.
    - Write edge → WREQ.
    - If `img_mounted` is 0, or a write arrives while `img_readonly` is 1: go straight to DONE with `err` = 1 and issue no host request.
  - **RREQ.** `blk_rd` = 1. On `blk_ack`: drop `blk_rd` → RSTREAM.
  - **RSTREAM.** On each `rd_valid`: `ram_addr` = `cnt[8:0]`, `ram_di` = `rd_data`, `ram_we` = 1 for that cycle, and `cnt` increments. After the 512th byte (`cnt` reaches 512) → DONE.
  - **WREQ.** `blk_wr` = 1. On `blk_ack`: drop `blk_wr` → WFETCH.
  - **WFETCH.** Drive `ram_addr` = `cnt[8:0]`, wait 1 cycle, capture `ram_do` into `wr_data` → WSEND.
  - **WSEND.** `wr_valid` = 1 and held, with `wr_data` stable, until `wr_ready`. On handshake `cnt` increments; if `cnt` = 512 → DONE, else → WFETCH.
  - **DONE.** `done` = 1 for 1 cycle → IDLE.
- **Timeout.** A counter clears on every state change and on every `rd_valid` or write handshake, and increments otherwise while in RREQ, WREQ, RSTREAM or WSEND. When it reaches `TIMEOUT`: all strobes drop, `err` = 1 → DONE.
- **Extra data.** `rd_valid` outside RSTREAM is ignored.
- **`busy`** = 1 in every state except IDLE.

## Timing
- **Reset values.** All outputs 0. The registered edge-detect copies of `hdd_read`/`hdd_write` reset to 0, so a level already high at reset release counts as a rising edge on the first cycle out of reset. State = IDLE, `cnt` = 0, `err` = 0.
- **Reset mid-transfer** aborts immediately without a `done` pulse.
- **Latencies:**
  - Request edge to `blk_rd`/`blk_wr` high: 2 cycles (1 for the edge register, 1 for the state register).
  - `blk_ack` to the strobe dropping: 1 cycle.
  - `rd_valid` to `ram_we`: 1 cycle, registered, with `ram_addr`/`ram_di` registered in the same cycle.
  - Write direction: at least 2 cycles per byte (fetch plus send); with `wr_ready` held at 1, 512 bytes take 1024 cycles.
  - Last byte to `done`: 1 cycle.
- **Status outputs.** `hdd_mounted` and `hdd_protect` lag the image inputs by 1 cycle.

## Test plan
- **Read.** Mounted image; `hdd_sector` = 0x0012, pulse `hdd_read`; ack; stream 512 bytes of value (i & 0xFF). Required: `blk_lba` = 0x12, buffer holds the pattern at 0..511, exactly 512 `ram_we` strobes, one `done` with `err` = 0.
- **Write with backpressure.** Buffer preloaded with 0xA5 ^ i; pulse `hdd_write`; ack; toggle `wr_ready` 1-of-3 cycles. Required: 512 bytes of 0xA5 ^ i in order, `wr_data` stable while stalled, `done` with `err` = 0.
- **Rejected requests.** Write with `img_readonly` = 1 → `done` with `err` = 1, `blk_wr` never asserted. Read with `img_mounted` = 0 → same response, `blk_rd` never asserted.
- **Simultaneous and busy edges.** `hdd_read` and `hdd_write` rise in the same cycle → read transfer only. A second `hdd_read` edge during RSTREAM → ignored, 512 bytes total.
- **Timeout.** `TIMEOUT` = 16, stop `rd_valid` after 100 bytes → `done` with `err` = 1 after 16 idle cycles, `busy` returns to 0.
- **Reset mid-stream.** Assert `reset` at byte 300 → next cycle all outputs 0 and no `done`. A fresh read afterwards completes normally.
